// File: rtl/switch_egress_arbiter_pkg.sv
// switch_egress_arbiter_pkg -- shared AXIS stream types, FSM encoding and constants (rev 1.0)
`default_nettype none

package switch_egress_arbiter_pkg;

`ifndef AXIS_DEST_WIDTH
`define AXIS_DEST_WIDTH 4
`endif

  localparam int AXIS_DEST_W = `AXIS_DEST_WIDTH;
  localparam logic [15:0] ABORT_TDATA = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FORWARD = 2'd1,
    ST_ABORT   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [15:0]            tdata;
    logic [AXIS_DEST_W-1:0] tdest;
    logic                   tlast;
    logic                   tvalid;
  } axis_d_source_t;

  typedef struct packed {
    logic tready;
  } axis_d_sink_t;

endpackage

`default_nettype wire

// File: rtl/switch_egress_arbiter_rr_picker.sv
// switch_rr_picker -- combinational round-robin select: first requester after last_grant, wrapping (rev 1.0)
`default_nettype none

module switch_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic               any_req,
  output logic [IDX_W-1:0]   sel_idx
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any_req  = |req;
    sel_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand     = (int'(last_grant) + k) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (req[cand_idx]) begin
        sel_idx = cand_idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/switch_egress_arbiter.sv
// switch_egress_arbiter -- round-robin frame arbiter for one egress port with abandon recovery (rev 1.0)
// Optional statistics counters enabled by defining SWITCH_ARB_STATS_EN.
`default_nettype none

module switch_egress_arbiter
  import switch_egress_arbiter_pkg::*;
#(
  parameter int                     NUM_REQ         = 4,
  parameter logic [AXIS_DEST_W-1:0] PORT_ID         = '0,
  parameter int                     STALL_CTR_WIDTH = 4,
  localparam int                    IDX_W           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  axis_d_source_t [NUM_REQ-1:0]  ingress_source,
  output axis_d_sink_t   [NUM_REQ-1:0]  ingress_sink,
  output axis_d_source_t                egress_source,
  input  axis_d_sink_t                  egress_sink,
  output logic                          grant_active,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          frame_abort
`ifdef SWITCH_ARB_STATS_EN
  ,
  output logic [31:0]                   frame_count,
  output logic [15:0]                   abort_count
`endif
);

  arb_state_t               state;
  logic [IDX_W-1:0]         last_grant;
  logic [IDX_W-1:0]         sel_idx;
  logic [NUM_REQ-1:0]       req;
  logic                     any_req;
  logic [STALL_CTR_WIDTH:0] stall_cnt;
  logic [STALL_CTR_WIDTH:0] stall_next;
  axis_d_source_t           granted;
  logic                     egress_hs;

  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i] = ingress_source[i].tvalid && (ingress_source[i].tdest == PORT_ID);
    end
  end

  switch_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req        (req),
    .last_grant (last_grant),
    .any_req    (any_req),
    .sel_idx    (sel_idx)
  );

  assign granted      = ingress_source[grant_idx];
  assign stall_next   = stall_cnt + {{STALL_CTR_WIDTH{1'b0}}, 1'b1};
  assign grant_active = (state == ST_FORWARD) || (state == ST_ABORT);
  assign egress_hs    = egress_source.tvalid && egress_sink.tready;

  always_comb begin
    egress_source = '0;
    ingress_sink  = '0;
    case (state)
      ST_FORWARD: begin
        egress_source.tdata       = granted.tdata;
        egress_source.tlast       = granted.tlast;
        egress_source.tvalid      = granted.tvalid;
        egress_source.tdest       = PORT_ID;
        ingress_sink[grant_idx].tready = egress_sink.tready;
      end
      ST_ABORT: begin
        egress_source.tdata  = ABORT_TDATA;
        egress_source.tlast  = 1'b1;
        egress_source.tvalid = 1'b1;
        egress_source.tdest  = PORT_ID;
      end
      default: begin
        egress_source = '0;
      end
    endcase
  end

  // The grant is latched on entry to FORWARD, so later tdest changes cannot steal it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      grant_idx   <= '0;
      stall_cnt   <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          stall_cnt <= '0;
          if (any_req) begin
            grant_idx <= sel_idx;
            state     <= ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (granted.tvalid) begin
            stall_cnt <= '0;
            if (egress_sink.tready && granted.tlast) begin
              state      <= ST_IDLE;
              last_grant <= grant_idx;
            end
          end else begin
            stall_cnt <= stall_next;
            if (stall_next[STALL_CTR_WIDTH]) begin
              state <= ST_ABORT;
            end
          end
        end
        ST_ABORT: begin
          if (egress_sink.tready) begin
            state       <= ST_IDLE;
            last_grant  <= grant_idx;
            frame_abort <= 1'b1;
            stall_cnt   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SWITCH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
      abort_count <= '0;
    end else begin
      if (egress_hs && egress_source.tlast && (frame_count != 32'hFFFF_FFFF)) begin
        frame_count <= frame_count + 32'd1;
      end
      if ((state == ST_ABORT) && egress_sink.tready && (abort_count != 16'hFFFF)) begin
        abort_count <= abort_count + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_switch_egress_arbiter.sv
// tb_switch_egress_arbiter -- scoreboard bench for the egress arbiter (rev 1.0)
`default_nettype none

module tb_switch_egress_arbiter;
  import switch_egress_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam logic [AXIS_DEST_W-1:0] PID = AXIS_DEST_W'(5);

  logic clk;
  logic reset;
  axis_d_source_t [NREQ-1:0] ingress_source;
  axis_d_sink_t   [NREQ-1:0] ingress_sink;
  axis_d_source_t            egress_source;
  axis_d_sink_t              egress_sink;
  logic                      grant_active;
  logic [1:0]                grant_idx;
  logic                      frame_abort;
`ifdef SWITCH_ARB_STATS_EN
  logic [31:0] frame_count;
  logic [15:0] abort_count;
`endif

  switch_egress_arbiter #(
    .NUM_REQ         (NREQ),
    .PORT_ID         (PID),
    .STALL_CTR_WIDTH (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .ingress_source (ingress_source),
    .ingress_sink   (ingress_sink),
    .egress_source  (egress_source),
    .egress_sink    (egress_sink),
    .grant_active   (grant_active),
    .grant_idx      (grant_idx),
    .frame_abort    (frame_abort)
`ifdef SWITCH_ARB_STATS_EN
    ,
    .frame_count    (frame_count),
    .abort_count    (abort_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester models: a frame per requester, optionally abandoned after fr_stop beats.
  logic [15:0]            fr_data [NREQ][8];
  int                     fr_len  [NREQ];
  int                     fr_pos  [NREQ];
  int                     fr_stop [NREQ];
  logic [AXIS_DEST_W-1:0] fr_dest [NREQ];
  bit                     fr_act  [NREQ];
  bit                     hs      [NREQ];

  always_comb begin
    ingress_source = '0;
    for (int i = 0; i < NREQ; i++) begin
      ingress_source[i].tdest  = fr_dest[i];
      ingress_source[i].tdata  = fr_data[i][fr_pos[i][2:0]];
      ingress_source[i].tlast  = (fr_pos[i] == fr_len[i] - 1);
      ingress_source[i].tvalid = fr_act[i] && !(fr_stop[i] >= 0 && fr_pos[i] >= fr_stop[i]);
    end
  end

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic [1:0]  idx;
    bit          abort;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   popped = 0;
  int   fa_count = 0;
  bit   mon_en = 1'b0;
  bit   exp_pulse = 1'b0;
  bit   prev_tlast = 1'b0;

  logic [NREQ-1:0] snap_rdy;
  logic            snap_ga;
  logic [1:0]      snap_gidx;
  logic            snap_evalid;
  logic [15:0]     snap_edata;
  logic            snap_elast;
  logic            snap_fa;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) snap_rdy[i] = ingress_sink[i].tready;
    snap_ga     = grant_active;
    snap_gidx   = grant_idx;
    snap_evalid = egress_source.tvalid;
    snap_edata  = egress_source.tdata;
    snap_elast  = egress_source.tlast;
    snap_fa     = frame_abort;
    if (snap_fa) fa_count++;
    if (mon_en) begin
      chk("frame_abort", frame_abort, exp_pulse);
      exp_pulse = 1'b0;
      if (prev_tlast) chk("bubble", egress_source.tvalid, 0);
      prev_tlast = 1'b0;
      chk("rdy_sel", (snap_rdy == 0) || (snap_rdy == (4'b1 << grant_idx)), 1);
      if (egress_source.tvalid && egress_sink.tready) begin
        if (sb.size() == 0) begin
          chk("extra_beat", egress_source.tdata, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("beat_data", egress_source.tdata, e.data);
          chk("beat_last", egress_source.tlast, e.last);
          chk("beat_idx", grant_idx, e.idx);
          chk("beat_dest", egress_source.tdest, PID);
          if (e.abort) exp_pulse = 1'b1;
          if (e.last) prev_tlast = 1'b1;
          popped++;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) hs[i] = ingress_source[i].tvalid && ingress_sink[i].tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (hs[i]) begin
        fr_pos[i]++;
        if (fr_pos[i] >= fr_len[i]) fr_act[i] = 1'b0;
      end
    end
  endtask

  task automatic load(input int r, input int len, input int base,
                      input logic [AXIS_DEST_W-1:0] dest, input int stop, input bit push);
    exp_t e;
    for (int k = 0; k < len; k++) fr_data[r][k] = 16'(base + k);
    fr_len[r]  = len;
    fr_pos[r]  = 0;
    fr_stop[r] = stop;
    fr_dest[r] = dest;
    fr_act[r]  = 1'b1;
    if (push) begin
      for (int k = 0; k < ((stop >= 0) ? stop : len); k++) begin
        e.data = 16'(base + k); e.last = (k == len - 1); e.idx = 2'(r); e.abort = 1'b0;
        sb.push_back(e);
      end
      if (stop >= 0) begin
        e.data = 16'h0000; e.last = 1'b1; e.idx = 2'(r); e.abort = 1'b1;
        sb.push_back(e);
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic wait_popped(input int target);
    int n;
    n = 0;
    while (popped < target && n < 100) begin
      step();
      n++;
    end
    if (popped < target) chk("wait_beats", popped, target);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    step();
    step();
    reset = 1'b0;
    sb.delete();
    for (int i = 0; i < NREQ; i++) begin
      fr_act[i] = 1'b0;
      fr_pos[i] = 0;
    end
    exp_pulse  = 1'b0;
    prev_tlast = 1'b0;
    mon_en     = 1'b1;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ga"}, snap_ga, 0);
    chk({tag, "_gidx"}, snap_gidx, 0);
    chk({tag, "_evalid"}, snap_evalid, 0);
    chk({tag, "_edata"}, snap_edata, 0);
    chk({tag, "_elast"}, snap_elast, 0);
    chk({tag, "_rdy"}, snap_rdy, 0);
    chk({tag, "_fa"}, snap_fa, 0);
  endtask

  initial begin
    int p0, fa0, stall, n;
    bit got;
    reset = 1'b1;
    egress_sink.tready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 8; k++) fr_data[i][k] = '0;
      fr_len[i] = 1; fr_pos[i] = 0; fr_stop[i] = -1; fr_dest[i] = PID; fr_act[i] = 1'b0;
    end

    apply_reset();
    step();
    check_idle_zero("rst");
`ifdef SWITCH_ARB_STATS_EN
    chk("rst_fcnt", frame_count, 0);
    chk("rst_acnt", abort_count, 0);
`endif

    // Single frame on requester 2, one cycle grant latency
    load(2, 3, 16'h00A1, PID, -1, 1);
    step();
    chk("t1_lat0", snap_rdy[2], 0);
    step();
    chk("t1_lat1", snap_rdy[2], 1);
    chk("t1_ga", snap_ga, 1);
    chk("t1_gidx", snap_gidx, 2);
    drain();
    step();
    chk("t1_idle", snap_ga, 0);

    // Foreign tdest is never granted
    load(1, 2, 16'h0C00, PID + 1'b1, -1, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t3_rdy", snap_rdy[1], 0);
      chk("t3_evalid", snap_evalid, 0);
    end
    fr_act[1] = 1'b0;

    // Round-robin from reset: 0,1,3 then 0 again
    apply_reset();
    load(0, 1, 16'h0B00, PID, -1, 1);
    load(1, 1, 16'h0B01, PID, -1, 1);
    load(3, 1, 16'h0B03, PID, -1, 1);
    drain();
    load(0, 1, 16'h0B10, PID, -1, 1);
    drain();

    // Backpressure 20 cycles mid-frame: no abort, data held
    p0 = popped;
    load(0, 4, 16'h00C1, PID, -1, 1);
    wait_popped(p0 + 2);
    egress_sink.tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("t4_valid", snap_evalid, 1);
      chk("t4_data", snap_edata, 16'h00C3);
    end
    egress_sink.tready = 1'b1;
    drain();

    // Abandon after 2 beats: 16 stall cycles, synthetic tlast, then requester 2
    p0  = popped;
    fa0 = fa_count;
    load(1, 5, 16'h00D1, PID, 2, 1);
    load(2, 1, 16'h00E1, PID, -1, 1);
    wait_popped(p0 + 2);
    stall = 0;
    got   = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (snap_evalid) got = 1'b1;
      else if (snap_ga) stall++;
    end
    chk("t5_abort_seen", got, 1);
    chk("t5_stall", stall, 16);
    drain();
    step();
    chk("t5_pulses", fa_count - fa0, 1);
    fr_act[1] = 1'b0;

    // Reset mid-frame, then all request: requester 0 first
    mon_en = 1'b0;
    for (int i = 0; i < NREQ; i++) load(i, 3, 16'h0100 * (i + 1), PID, -1, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (!snap_ga && n < 10);
    step();
    chk("t6_fwd", snap_ga, 1);
    apply_reset();
    for (int i = 0; i < NREQ; i++) load(i, 1, 16'h0F00 + i, PID, -1, 1);
    step();
    check_idle_zero("t6");
`ifdef SWITCH_ARB_STATS_EN
    chk("t6_fcnt0", frame_count, 0);
    chk("t6_acnt0", abort_count, 0);
`endif
    step();
    chk("t6_first", snap_gidx, 0);
    drain();
    step();
`ifdef SWITCH_ARB_STATS_EN
    chk("t6_fcnt", frame_count, 4);
    chk("t6_acnt", abort_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
